// File: rtl/pending_bit_dispatcher_if.sv
// rtl/pending_bit_dispatcher_if.sv - set/dispatch bus of the pending-bit dispatcher
// master drives event sets and accepts dispatched indices; slave is the dispatcher.
interface pending_bit_dispatcher_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             set_valid;
    logic [WIDTH-1:0] set_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_pos;
    logic [WIDTH-1:0] pending;
    logic             overflow;

    modport master (
        output set_valid, set_mask, out_ready,
        input  out_valid, out_pos, pending, overflow
    );

    modport slave (
        input  set_valid, set_mask, out_ready,
        output out_valid, out_pos, pending, overflow
    );
endinterface

// File: rtl/pending_bit_dispatcher.sv
// rtl/pending_bit_dispatcher.sv - latches event bits and dispatches one index at a time
// Optional macro PDB_ROUND_ROBIN_EN: round-robin selection instead of lowest-bit-first.
module pending_bit_dispatcher #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    pending_bit_dispatcher_if.slave  bus
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d, smask, load_onehot;
    logic [IDX_W-1:0] sel_idx, out_pos_q;
    logic             overflow_q, pop, load;

    assign smask = bus.set_valid ? bus.set_mask : '0;
    assign pop   = (state_q == FULL) & bus.out_ready;

`ifdef PDB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_ptr_q, scan;
    logic             found;

    // Scan starts just past the last dispatched index; reset value makes the first scan start at 0.
    always_comb begin
        sel_idx = '0;
        scan    = '0;
        found   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            scan = last_ptr_q + IDX_W'(i + 1);
            if (!found && pending_q[scan]) begin
                sel_idx = scan;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ptr_q <= IDX_W'(WIDTH - 1);
        end else if (load) begin
            last_ptr_q <= sel_idx;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        load    = ((state_q == IDLE) | pop) & (|pending_q);
        case (state_q)
            IDLE: if (load) state_d = FULL;
            FULL: if (pop && !load) state_d = IDLE;
        endcase
    end

    always_comb begin
        load_onehot = '0;
        if (load) begin
            load_onehot[sel_idx] = 1'b1;
        end
    end

    // A same-cycle set beats the dispatch clear, so the bit stays pending.
    assign pending_d = (pending_q & ~load_onehot) | smask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            out_pos_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_q | (|(pending_q & ~load_onehot & smask));
            if (load) begin
                out_pos_q <= sel_idx;
            end
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_pos   = out_pos_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pending_bit_dispatcher.sv
// tb/tb_pending_bit_dispatcher.sv - scoreboard bench for pending_bit_dispatcher
module tb_pending_bit_dispatcher;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    pending_bit_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    pending_bit_dispatcher #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        reset         = 1'b1;
        bus.set_valid = 1'b0;
        bus.set_mask  = '0;
        bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            check_eq("pop_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check_eq("out_pos", 32'(bus.out_pos), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with an empty set mask
        bus.set_valid = 1'b1;
        bus.set_mask  = '0;
        bus.out_ready = 1'b0;
        repeat (5) step();
        sample();
        check_eq("t1_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t1_pending",   32'(bus.pending),   32'h00);
        check_eq("t1_overflow",  32'(bus.overflow),  32'd0);
        check_eq("t1_out_pos",   32'(bus.out_pos),   32'd0);

        // Lowest-first drain of 0xA4 with one-per-cycle dispatch
        step();
        reset         = 1'b0;
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'hA4;
        bus.out_ready = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(5);
        exp_q.push_back(7);
        step();
        bus.set_valid = 1'b0;
        sample();
        check_eq("t2_pending_n1", 32'(bus.pending),   32'hA4);
        check_eq("t2_valid_n1",   32'(bus.out_valid), 32'd0);
        step();
        sample();
        check_eq("t2_valid_n2",   32'(bus.out_valid), 32'd1);
        step();
        step();
        sample();
        check_eq("t2_pending_n4", 32'(bus.pending),   32'h00);
        check_eq("t2_valid_n4",   32'(bus.out_valid), 32'd1);
        step();
        sample();
        check_eq("t2_valid_n5",   32'(bus.out_valid), 32'd0);
        check_eq("t2_q_empty",    32'(exp_q.size()),  32'd0);

        // Stall holds output; re-setting the held bit is legal
        do_reset();
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h01;
        exp_q.push_back(0);
        step();
        bus.set_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            sample();
            check_eq("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("t3_hold_pos",   32'(bus.out_pos),   32'd0);
            step();
        end
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h01;
        exp_q.push_back(0);
        step();
        bus.set_valid = 1'b0;
        sample();
        check_eq("t3_repend",   32'(bus.pending),  32'h01);
        check_eq("t3_overflow", 32'(bus.overflow), 32'd0);
        step();
        bus.out_ready = 1'b1;
        repeat (3) step();
        sample();
        check_eq("t3_valid_end", 32'(bus.out_valid), 32'd0);
        check_eq("t3_q_empty",   32'(exp_q.size()),  32'd0);

        // Setting an already-pending bit raises sticky overflow
        do_reset();
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h03;
        exp_q.push_back(0);
        exp_q.push_back(1);
        step();
        bus.set_valid = 1'b0;
        step();
        step();
        sample();
        check_eq("t4_pending",  32'(bus.pending),  32'h02);
        check_eq("t4_ovf_pre",  32'(bus.overflow), 32'd0);
        step();
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h02;
        step();
        bus.set_valid = 1'b0;
        sample();
        check_eq("t4_ovf_set",  32'(bus.overflow), 32'd1);
        repeat (3) step();
        sample();
        check_eq("t4_ovf_held", 32'(bus.overflow), 32'd1);
        step();
        bus.out_ready = 1'b1;
        repeat (4) step();
        sample();
        check_eq("t4_ovf_drain", 32'(bus.overflow),  32'd1);
        check_eq("t4_valid_end", 32'(bus.out_valid), 32'd0);
        check_eq("t4_q_empty",   32'(exp_q.size()),  32'd0);

        // Reset dominates a same-cycle set and drops held and pending state
        step();
        bus.out_ready = 1'b0;
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h01;
        step();
        bus.set_valid = 1'b0;
        step();
        step();
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h40;
        step();
        bus.set_valid = 1'b0;
        sample();
        check_eq("t5_pending_pre", 32'(bus.pending),   32'h40);
        check_eq("t5_valid_pre",   32'(bus.out_valid), 32'd1);
        check_eq("t5_ovf_pre",     32'(bus.overflow),  32'd1);
        step();
        reset         = 1'b1;
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'hFF;
        step();
        reset         = 1'b0;
        bus.set_valid = 1'b0;
        sample();
        check_eq("t5_pending", 32'(bus.pending),   32'h00);
        check_eq("t5_valid",   32'(bus.out_valid), 32'd0);
        check_eq("t5_ovf",     32'(bus.overflow),  32'd0);

        // Two bits kept pending show the selection policy
        step();
        bus.out_ready = 1'b1;
        bus.set_valid = 1'b1;
        bus.set_mask  = 8'h81;
`ifdef PDB_ROUND_ROBIN_EN
        for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 0) ? 0 : 7);
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(0);
        exp_q.push_back(7);
`endif
        repeat (6) step();
        bus.set_valid = 1'b0;
        repeat (4) step();
        sample();
        check_eq("t6_q_empty", 32'(exp_q.size()),  32'd0);
        check_eq("t6_valid",   32'(bus.out_valid), 32'd0);
        check_eq("t6_pending", 32'(bus.pending),   32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
